// File: rtl/mux2_reg_pkg.sv
// Shared constants for the mux2_reg slice: default widths and the saturation value
// of the optional select-switch counter.
package mux2_reg_pkg;

   localparam int DEF_WIDTH = 1;
   localparam int DEF_CNT_W = 8;

   // All-ones value of a w-bit counter; the switch counter stops here.
   function automatic longint unsigned cnt_sat_value(input int w);
      return (longint'(1) << w) - 1;
   endfunction

   localparam longint unsigned DEF_CNT_SAT = cnt_sat_value(DEF_CNT_W);

endpackage : mux2_reg_pkg

// File: rtl/mux2_reg_if.sv
// Bus bundle for mux2_reg: data sources, select, enable and the mux outputs.
// sw_cnt (and CNT_W) exist only when MUX2_SWITCH_CNT_EN is defined.
interface mux2_reg_if
   import mux2_reg_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
`ifdef MUX2_SWITCH_CNT_EN
   ,
   parameter int CNT_W = DEF_CNT_W
`endif
);

   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             s;
   logic             en;
   logic [WIDTH-1:0] y;
   logic [WIDTH-1:0] y_q;
   logic             s_q;
`ifdef MUX2_SWITCH_CNT_EN
   logic [CNT_W-1:0] sw_cnt;
`endif

   modport master (
      output a, b, s, en,
      input  y, y_q, s_q
`ifdef MUX2_SWITCH_CNT_EN
      , input sw_cnt
`endif
   );

   modport slave (
      input  a, b, s, en,
      output y, y_q, s_q
`ifdef MUX2_SWITCH_CNT_EN
      , output sw_cnt
`endif
   );

endinterface : mux2_reg_if

// File: rtl/mux2_reg_core.sv
// mux2_core: purely combinational WIDTH-bit 2:1 select, y = s ? b : a.
module mux2_core
   import mux2_reg_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_s,
   output logic [WIDTH-1:0] o_y
);

   assign o_y = i_s ? i_b : i_a;

endmodule : mux2_core

// File: rtl/mux2_reg.sv
// 2:1 mux with a combinational result, a registered copy and a registered select echo.
// Define MUX2_SWITCH_CNT_EN to add a saturating count of select changes (sw_cnt).
module mux2_reg
   import mux2_reg_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
`ifdef MUX2_SWITCH_CNT_EN
   ,
   parameter int CNT_W = DEF_CNT_W
`endif
) (
   input  logic       clk,
   input  logic       rst,
   mux2_reg_if.slave  bus
);

   logic [WIDTH-1:0] w_y;
   logic [WIDTH-1:0] r_y_q;
   logic             r_s_q;

   mux2_core #(.WIDTH(WIDTH)) u_core (
      .i_a (bus.a),
      .i_b (bus.b),
      .i_s (bus.s),
      .o_y (w_y)
   );

   assign bus.y   = w_y;
   assign bus.y_q = r_y_q;
   assign bus.s_q = r_s_q;

   // NOTE: reset is sampled on the clock edge (synchronous) and outranks en.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_y_q <= '0;
         r_s_q <= 1'b0;
      end else if (bus.en) begin
         r_y_q <= w_y;
         r_s_q <= bus.s;
      end
   end

`ifdef MUX2_SWITCH_CNT_EN
   localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(cnt_sat_value(CNT_W));

   logic [CNT_W-1:0] r_sw_cnt;

   // Counts enabled edges where the select differs from its registered echo.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sw_cnt <= '0;
      end else if (bus.en && (bus.s != r_s_q) && (r_sw_cnt != CNT_SAT)) begin
         r_sw_cnt <= r_sw_cnt + CNT_W'(1);
      end
   end

   assign bus.sw_cnt = r_sw_cnt;
`endif

endmodule : mux2_reg

// File: tb/tb_mux2_reg.sv
// Scoreboard bench for mux2_reg: a WIDTH=1 and a WIDTH=8 instance share select/enable/reset;
// expected registered results are queued per edge and checked by an independent monitor.
module tb_mux2_reg;
   import mux2_reg_pkg::*;

   localparam int CW      = 2;
   localparam int CNT_MAX = (1 << CW) - 1;
   // y for WIDTH=1 indexed by {a,b,s}: 000..111 -> 0,0,0,1,1,0,1,1
   localparam logic [7:0] TRUTH = 8'b1101_1000;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

`ifdef MUX2_SWITCH_CNT_EN
   mux2_reg_if #(.WIDTH(1), .CNT_W(CW)) bus1 ();
   mux2_reg_if #(.WIDTH(8), .CNT_W(CW)) bus8 ();
   mux2_reg #(.WIDTH(1), .CNT_W(CW)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
   mux2_reg #(.WIDTH(8), .CNT_W(CW)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
`else
   mux2_reg_if #(.WIDTH(1)) bus1 ();
   mux2_reg_if #(.WIDTH(8)) bus8 ();
   mux2_reg #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
   mux2_reg #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
`endif

   typedef struct {
      int         idx;
      logic       y_q1;
      logic [7:0] y_q8;
      logic       s_q;
      int         cnt;
   } exp_t;

   exp_t sb[$];

   int tests = 0;
   int fails = 0;
   int step_no = 0;

   // Reference state: what the registered outputs should hold after each edge.
   logic       m_yq1 = 1'b0;
   logic [7:0] m_yq8 = 8'h00;
   logic       m_sq  = 1'b0;
   int         m_cnt = 0;

   task automatic check(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s (step %0d): got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   // One clock period: apply inputs after the falling edge, check the combinational
   // result, then queue what the registers must show after the next rising edge.
   task automatic step(input logic a1, input logic b1, input logic [7:0] a8,
                       input logic [7:0] b8, input logic s, input logic en, input logic r);
      exp_t e;
      @(negedge clk);
      bus1.a = a1;  bus1.b = b1;  bus1.s = s;  bus1.en = en;
      bus8.a = a8;  bus8.b = b8;  bus8.s = s;  bus8.en = en;
      rst    = r;
      step_no++;
      #4;
      check("y1", step_no, 32'(bus1.y), 32'(TRUTH[{a1, b1, s}]));
      check("y8", step_no, 32'(bus8.y), 32'((a8 & ~{8{s}}) | (b8 & {8{s}})));

      if (r) begin
         m_yq1 = 1'b0;
         m_yq8 = 8'h00;
         m_sq  = 1'b0;
         m_cnt = 0;
      end else if (en) begin
         if (s != m_sq && m_cnt < CNT_MAX) m_cnt++;
         m_yq1 = TRUTH[{a1, b1, s}];
         m_yq8 = s ? b8 : a8;
         m_sq  = s;
      end
      e.idx  = step_no;
      e.y_q1 = m_yq1;
      e.y_q8 = m_yq8;
      e.s_q  = m_sq;
      e.cnt  = m_cnt;
      sb.push_back(e);
   endtask

   // Monitor: every rising edge presents a new registered result.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("y_q1", e.idx, 32'(bus1.y_q), 32'(e.y_q1));
            check("y_q8", e.idx, 32'(bus8.y_q), 32'(e.y_q8));
            check("s_q1", e.idx, 32'(bus1.s_q), 32'(e.s_q));
            check("s_q8", e.idx, 32'(bus8.s_q), 32'(e.s_q));
`ifdef MUX2_SWITCH_CNT_EN
            check("sw_cnt1", e.idx, 32'(bus1.sw_cnt), 32'(e.cnt));
            check("sw_cnt8", e.idx, 32'(bus8.sw_cnt), 32'(e.cnt));
`endif
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [2:0] abs;
      bus1.a = '0; bus1.b = '0; bus1.s = 1'b0; bus1.en = 1'b0;
      bus8.a = '0; bus8.b = '0; bus8.s = 1'b0; bus8.en = 1'b0;
      rst = 1'b1;

      step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);

      // Combinational sweep of every (a,b,s) with the registers frozen.
      for (int i = 0; i < 8; i++) begin
         abs = 3'(i);
         step(abs[2], abs[1], 8'h5A, 8'hC3, abs[0], 1'b0, 1'b0);
      end

      // Reset beats enable; y still follows the inputs.
      step(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1);

      // Registered path and enable hold.
      step(1'b0, 1'b1, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 8'h00, 8'hFF, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

      // Wide data patterns.
      step(1'b1, 1'b0, 8'hA5, 8'h3C, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 8'hA5, 8'h3C, 1'b1, 1'b1, 1'b0);

      // Select toggles on consecutive enabled edges drive the counter into saturation.
      step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h11, 8'hEE, ~i[0], 1'b1, 1'b0);
      step(1'b1, 1'b0, 8'h11, 8'hEE, 1'b0, 1'b1, 1'b1);

      // Randomized traffic with occasional mid-stream resets.
      for (int i = 0; i < 200; i++) begin
         step(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
      end

      repeat (2) @(negedge clk);
      check("scoreboard drained", step_no, 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_mux2_reg

// File: doc/mux2_reg.md
Name: mux2_reg

Overview:
- Parameterised 2:1 multiplexer.
- Primary path is purely combinational: y = a when s=0, y = b when s=1.
- A clocked copy of the result (y_q) is provided for timing-closure use, along with a registered select echo.
- Used wherever a datapath must choose between two sources, in both combinational and registered contexts.

Parameters:
- WIDTH, 1, bit width of a, b, y, y_q.
- CNT_W, 8, width of the select-switch counter (used only with MUX2_SWITCH_CNT_EN).

Ports:
- clk  input  1  rising-edge clock for all registered outputs.
- rst  input  1  synchronous, active-high reset.
- a  input  WIDTH  data source selected when s=0.
- b  input  WIDTH  data source selected when s=1.
- s  input  1  select.
- en  input  1  register update enable for y_q and s_q.
- y  output  WIDTH  combinational mux result.
- y_q  output  WIDTH  registered mux result.
- s_q  output  1  registered select.
- sw_cnt  output  CNT_W  select-switch count; present only with MUX2_SWITCH_CNT_EN.

Behaviour:
- y = s ? b : a, bitwise across WIDTH.
  - Zero latency: no clock or reset dependency.
  - Must be settled well within 5 ns of any input change.
- Truth table for WIDTH=1, written (a,b,s -> y): 000->0, 010->0, 100->1, 110->1, 001->0, 011->1, 101->0, 111->1.
- Reset:
  - rst=1 at a rising clk edge sets y_q=0, s_q=0, sw_cnt=0.
  - rst takes priority over en.
  - y is not affected by rst.
- At a rising edge with rst=0 and en=1: y_q <= (s ? b : a) as sampled at that edge; s_q <= s. Latency is one cycle from inputs to y_q.
- At a rising edge with rst=0 and en=0: y_q and s_q hold their values.
- Reset asserted mid-stream clears the registers on that edge. The first post-reset update occurs at the first edge with rst=0 and en=1.
- X or Z on s is not a legal operating condition. The implementation uses a plain conditional select; no X-pessimism handling is required.
- No handshake; every input is accepted every cycle.

Optional Feature:
- Macro: MUX2_SWITCH_CNT_EN.
- Defined:
  - sw_cnt exists.
  - At each rising edge with rst=0 and en=1 where s differs from the current s_q, sw_cnt increments by 1.
  - sw_cnt saturates at 2^CNT_W-1 and does not wrap.
  - Reset clears sw_cnt to 0.
  - The first enabled edge after reset compares s against s_q=0.
- Undefined:
  - The sw_cnt port and its logic are absent.
  - All other behaviour is identical.

Decomposition:
- Package mux2_reg_pkg holds:
  - default WIDTH (1) and CNT_W (8) constants;
  - a localparam for the counter saturation value.
- One natural sub-module, mux2_core: purely combinational WIDTH-bit 2:1 select (a, b, s -> y).
  - Instantiated once in mux2_reg to drive y.
  - The registered stage samples mux2_core's output.

Test Plan:
- Combinational sweep, WIDTH=1, all 8 (a,b,s) combinations, 5 ns apart, rst=0 -> y matches the truth table at each 5 ns check (e.g., a=1,b=0,s=1 -> y=0; a=1,b=0,s=0 -> y=1).
- Reset: drive a=1,b=1,s=1,en=1,rst=1 for one edge -> y_q=0 and s_q=0 after the edge, while y=1 throughout.
- Registered path: rst=0, en=1, a=0,b=1,s=1 -> y_q=1 and s_q=1 one edge later; then switch to s=0 -> y_q=0 at the next edge.
- Enable hold: y_q=1, then en=0 with a=0,b=0 for 3 edges -> y_q stays 1, y=0; then en=1 -> y_q=0 at the next edge.
- Width check: WIDTH=8, a=8'hA5, b=8'h3C -> y=8'hA5 with s=0 and 8'h3C with s=1; y_q follows one cycle later.
- With MUX2_SWITCH_CNT_EN and CNT_W=2: toggle s on 5 consecutive enabled edges -> sw_cnt sequence 1,2,3,3,3; a reset edge -> sw_cnt=0.
